// File: rtl/integral_stream_generator_pkg.sv
// Shared types and default sizing for the streaming integral image generator.
// The default widths are sized for the integral / squared-integral caches:
// the largest possible sum of a full frame of maximum-value pixels.
package pkg_integralStream;

    typedef enum logic [1:0] {
        S_Idle  = 2'd0,
        S_Run   = 2'd1,
        S_Drain = 2'd2,
        S_Done  = 2'd3
    } STATES_t;

    localparam int DEF_IMG_WIDTH  = 320;
    localparam int DEF_IMG_HEIGHT = 240;
    localparam int DEF_PIX_WIDTH  = 8;

    // Largest integral / squared-integral value over one frame
    localparam longint DEF_INT_MAX = longint'(DEF_IMG_WIDTH) * DEF_IMG_HEIGHT
                                     * ((longint'(1) << DEF_PIX_WIDTH) - 1);
    localparam longint DEF_SQ_MAX  = longint'(DEF_IMG_WIDTH) * DEF_IMG_HEIGHT
                                     * ((longint'(1) << DEF_PIX_WIDTH) - 1)
                                     * ((longint'(1) << DEF_PIX_WIDTH) - 1);

    localparam int DEF_INT_WIDTH = $clog2(DEF_INT_MAX + 1);
    localparam int DEF_SQ_WIDTH  = $clog2(DEF_SQ_MAX + 1);

    // Coordinate counter width; never zero so a 1-row frame still has a y port
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/integral_stream_generator_line_buffer.sv
// Single-row line buffer: simple dual-port RAM with a registered read port.
// No reset on the array or read register so it maps onto block RAM.
module integral_line_buffer
    import pkg_integralStream::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH,
    parameter int WIDTH = DEF_INT_WIDTH,
    localparam int AW   = coord_width(DEPTH)
)(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port share the clock
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/integral_stream_generator.sv
// Streaming integral image generator: raster pixels in, integral image out.
// Define INTEGRAL_SQ_EN to build the squared-integral path as well; without it
// out_sq_integral is tied to zero.
// Stage 1 (accept edge): row sum updated, line-buffer read issued.
// Stage 2 (output visible): above + row sum presented, written back on handshake.
module integral_stream_generator
    import pkg_integralStream::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PIX_WIDTH  = DEF_PIX_WIDTH,
    parameter int INT_WIDTH  = DEF_INT_WIDTH,
    parameter int SQ_WIDTH   = DEF_SQ_WIDTH,
    localparam int XW        = coord_width(IMG_WIDTH),
    localparam int YW        = coord_width(IMG_HEIGHT)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_WIDTH-1:0] in_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT_WIDTH-1:0] out_integral,
    output logic [SQ_WIDTH-1:0]  out_sq_integral,
    output logic [XW-1:0]        out_x,
    output logic [YW-1:0]        out_y,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    STATES_t              state_reg;
    logic                 done_reg;
    logic [XW-1:0]        x_reg;
    logic [YW-1:0]        y_reg;
    logic [XW-1:0]        out_x_reg;
    logic [YW-1:0]        out_y_reg;
    logic                 out_valid_reg;
    logic                 use_above_reg;
    logic [INT_WIDTH-1:0] row_sum_reg;
    logic [INT_WIDTH-1:0] row_sum_next;
    logic [INT_WIDTH-1:0] above_raw;
    logic [INT_WIDTH-1:0] integral_val;

    logic accept;
    logic out_hs;
    logic last_pix;
    logic start_ok;

    assign in_ready  = (state_reg == S_Run) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid_reg && out_ready;
    assign last_pix  = (x_reg == X_LAST) && (y_reg == Y_LAST);
    assign start_ok  = start && ((state_reg == S_Idle) || (state_reg == S_Done));

    assign row_sum_next = ((x_reg == '0) ? '0 : row_sum_reg) + INT_WIDTH'(in_pixel);
    // Row 0 has nothing above it, so the (possibly uninitialised) RAM is masked
    assign integral_val = use_above_reg ? (above_raw + row_sum_reg) : row_sum_reg;

    assign out_valid    = out_valid_reg;
    assign out_integral = integral_val;
    assign out_x        = out_x_reg;
    assign out_y        = out_y_reg;
    assign out_last     = out_valid_reg && (out_x_reg == X_LAST) && (out_y_reg == Y_LAST);
    assign busy         = (state_reg == S_Run) || (state_reg == S_Drain);
    assign done         = done_reg;

    // Frame control: run until the last pixel is accepted, drain until its result leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_Idle;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_Idle, S_Done: begin
                    if (start) begin
                        state_reg <= S_Run;
                    end
                end
                S_Run: begin
                    if (accept && last_pix) begin
                        state_reg <= S_Drain;
                    end
                end
                S_Drain: begin
                    if (out_hs && out_last) begin
                        state_reg <= S_Done;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= S_Idle;
            endcase
        end
    end

    // Raster counters, running row sum and the stage-2 output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg         <= '0;
            y_reg         <= '0;
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            out_valid_reg <= 1'b0;
            use_above_reg <= 1'b0;
            row_sum_reg   <= '0;
        end else if (start_ok) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            if (accept) begin
                out_x_reg     <= x_reg;
                out_y_reg     <= y_reg;
                use_above_reg <= (y_reg != '0);
                row_sum_reg   <= row_sum_next;
                if (x_reg == X_LAST) begin
                    x_reg <= '0;
                    y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
                end else begin
                    x_reg <= x_reg + 1'b1;
                end
            end
            if (accept) begin
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    integral_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (INT_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (out_hs),
        .wr_addr (out_x_reg),
        .wr_data (integral_val),
        .rd_en   (accept),
        .rd_addr (x_reg),
        .rd_data (above_raw)
    );

`ifdef INTEGRAL_SQ_EN
    logic [2*PIX_WIDTH-1:0] pix_sq;
    logic [SQ_WIDTH-1:0]    row_sum_sq_reg;
    logic [SQ_WIDTH-1:0]    row_sum_sq_next;
    logic [SQ_WIDTH-1:0]    above_sq_raw;
    logic [SQ_WIDTH-1:0]    sq_val;

    assign pix_sq          = {{PIX_WIDTH{1'b0}}, in_pixel} * {{PIX_WIDTH{1'b0}}, in_pixel};
    assign row_sum_sq_next = ((x_reg == '0) ? '0 : row_sum_sq_reg) + SQ_WIDTH'(pix_sq);
    assign sq_val          = use_above_reg ? (above_sq_raw + row_sum_sq_reg) : row_sum_sq_reg;
    assign out_sq_integral = sq_val;

    // Running row sum of squared pixels, frozen like the plain row sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sum_sq_reg <= '0;
        end else if (accept && !start_ok) begin
            row_sum_sq_reg <= row_sum_sq_next;
        end
    end

    integral_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (SQ_WIDTH)
    ) u_line_buf_sq (
        .clk     (clk),
        .wr_en   (out_hs),
        .wr_addr (out_x_reg),
        .wr_data (sq_val),
        .rd_en   (accept),
        .rd_addr (x_reg),
        .rd_data (above_sq_raw)
    );
`else
    assign out_sq_integral = '0;
`endif

endmodule
